// File: rtl/irrigation_display_pkg.sv
// Shared types and constants for the irrigation display line multiplexer and its scanner.
package irrigation_display_pkg;

    localparam int unsigned LINE_W = 7;

    localparam logic SEL_N = 1'b0;
    localparam logic SEL_R = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StHold
    } scan_state_e;

endpackage

// File: rtl/phase_counter.sv
// Per-phase cycle counter with clear/increment and terminal compares for settle and dwell.
module phase_counter #(
    parameter int unsigned DWELL_CYCLES  = 50000,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic at_settle,
    output logic at_dwell
);

    localparam int unsigned CntW = $clog2(DWELL_CYCLES);

    logic [CntW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_settle = (cnt_q == CntW'(SETTLE_CYCLES - 1));
    assign at_dwell  = (cnt_q == CntW'(DWELL_CYCLES - 1));

endmodule

// File: rtl/line_demux_scanner.sv
// Drives the line-mux selector and demultiplexes the shared line bus into the n and r banks,
// sampling only after the bus has had SETTLE_CYCLES to follow a selector change.
module line_demux_scanner #(
    parameter int unsigned LINE_W        = irrigation_display_pkg::LINE_W,
    parameter int unsigned DWELL_CYCLES  = 50000,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [LINE_W-1:0] lines_in,
    output logic              selector,
    output logic [LINE_W-1:0] lines_n,
    output logic [LINE_W-1:0] lines_r,
    output logic              valid_n,
    output logic              valid_r,
    output logic              frame_done
);

    import irrigation_display_pkg::*;

    scan_state_e       state_d, state_q;
    logic              sel_d, sel_q;
    logic [LINE_W-1:0] lines_n_d, lines_n_q;
    logic [LINE_W-1:0] lines_r_d, lines_r_q;
    logic              valid_n_d, valid_n_q;
    logic              valid_r_d, valid_r_q;
    logic              cnt_clear, cnt_inc;
    logic              at_settle, at_dwell;

    phase_counter #(
        .DWELL_CYCLES  (DWELL_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_phase_counter (
        .clock     (clock),
        .reset     (reset),
        .clear     (cnt_clear),
        .inc       (cnt_inc),
        .at_settle (at_settle),
        .at_dwell  (at_dwell)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        lines_n_d = lines_n_q;
        lines_r_d = lines_r_q;
        valid_n_d = 1'b0;
        valid_r_d = 1'b0;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;

        // The sample edge captures even if enable drops on the same edge.
        if (state_q == StSample) begin
            if (sel_q == SEL_N) begin
                lines_n_d = lines_in;
                valid_n_d = 1'b1;
            end else begin
                lines_r_d = lines_in;
                valid_r_d = 1'b1;
            end
        end

        if (!enable) begin
            state_d   = StIdle;
            sel_d     = SEL_N;
            cnt_clear = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    sel_d     = SEL_N;
                    cnt_clear = 1'b1;
                    state_d   = StSettle;
                end
                StSettle: begin
                    cnt_inc = 1'b1;
                    if (at_settle) begin
                        state_d = StSample;
                    end
                end
                StSample: begin
                    cnt_inc = 1'b1;
                    state_d = StHold;
                end
                StHold: begin
                    if (at_dwell) begin
                        sel_d     = ~sel_q;
                        cnt_clear = 1'b1;
                        state_d   = StSettle;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: begin
                    state_d   = StIdle;
                    sel_d     = SEL_N;
                    cnt_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            sel_q     <= SEL_N;
            lines_n_q <= '0;
            lines_r_q <= '0;
            valid_n_q <= 1'b0;
            valid_r_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            lines_n_q <= lines_n_d;
            lines_r_q <= lines_r_d;
            valid_n_q <= valid_n_d;
            valid_r_q <= valid_r_d;
        end
    end

    assign selector   = sel_q;
    assign lines_n    = lines_n_q;
    assign lines_r    = lines_r_q;
    assign valid_n    = valid_n_q;
    assign valid_r    = valid_r_q;
    // An r capture always closes a frame because the scan starts on the n phase.
    assign frame_done = valid_r_q;

endmodule

// File: tb/tb_line_demux_scanner.sv
// Randomized self-checking bench for line_demux_scanner with a cycle-timing reference model.
module tb_line_demux_scanner;

    localparam int LW = 7;
    localparam int DW = 8;
    localparam int SC = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic [LW-1:0] lines_in;
    logic          selector;
    logic [LW-1:0] lines_n;
    logic [LW-1:0] lines_r;
    logic          valid_n;
    logic          valid_r;
    logic          frame_done;

    line_demux_scanner #(
        .LINE_W        (LW),
        .DWELL_CYCLES  (DW),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .lines_in   (lines_in),
        .selector   (selector),
        .lines_n    (lines_n),
        .lines_r    (lines_r),
        .valid_n    (valid_n),
        .valid_r    (valid_r),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    int            checks = 0;
    int            errors = 0;
    int            rel;
    logic [LW-1:0] hist [0:511];
    bit            fixed_data;
    bit            garbage_mode;
    logic          prev_sel;
    logic [LW-1:0] exp_n;
    logic [LW-1:0] exp_r;

    // Selector phase k spans cycles 1+k*DW .. k*DW+DW after enable; odd phases are r.
    function automatic logic m_sel(input int c);
        if (c < 1) return 1'b0;
        return (((c - 1) / DW) % 2) == 1;
    endfunction

    // Bank update visible SC+2 cycles into each phase.
    function automatic bit m_cap(input int c);
        return (c >= SC + 2) && (((c - SC - 2) % DW) == 0);
    endfunction

    task automatic model_cycle(output logic esel, output logic evn, output logic evr);
        esel = m_sel(rel);
        evn  = 1'b0;
        evr  = 1'b0;
        if (m_cap(rel)) begin
            if (!m_sel(rel - 1)) begin
                evn   = 1'b1;
                exp_n = hist[rel-1];
            end else begin
                evr   = 1'b1;
                exp_r = hist[rel-1];
            end
        end
    endtask

    // Multiplexer model: chosen set's value, optionally garbage for one cycle after a change.
    task automatic drive_bus();
        logic [LW-1:0] v;
        if (fixed_data) v = selector ? 7'h2A : 7'h55;
        else            v = 7'($urandom_range(126, 0));
        if (garbage_mode && selector !== prev_sel) v = 7'h7F;
        lines_in = v;
        if (rel >= 0 && rel < 512) hist[rel] = v;
        prev_sel = selector;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        rel++;
        drive_bus();
    endtask

    task automatic start_scan();
        enable   = 1'b1;
        rel      = 0;
        prev_sel = selector;
        drive_bus();
    endtask

    task automatic park();
        enable = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_reset();
        logic [17:0] got;
        reset    = 1'b1;
        enable   = 1'b1;
        lines_in = 7'h33;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            got = {selector, lines_n, lines_r, valid_n, valid_r, frame_done};
            checks++;
            if (got !== 18'h0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: got %h want %h", i, got, 18'h0);
            end
        end
        reset  = 1'b0;
        enable = 1'b0;
        exp_n  = '0;
        exp_r  = '0;
        step();
        got = {selector, lines_n, lines_r, valid_n, valid_r, frame_done};
        checks++;
        if (got !== 18'h0) begin
            errors++;
            $display("FAIL reset_idle: got %h want %h", got, 18'h0);
        end
    endtask

    task automatic test_basic_frame();
        logic esel, evn, evr;
        logic [17:0] got, want;
        logic [15:0] spot;
        fixed_data   = 1'b1;
        garbage_mode = 1'b0;
        start_scan();
        for (int i = 0; i < 14; i++) begin
            step();
            model_cycle(esel, evn, evr);
            want = {esel, exp_n, exp_r, evn, evr, evr};
            got  = {selector, lines_n, lines_r, valid_n, valid_r, frame_done};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL basic_frame cyc %0d: got %h want %h", rel, got, want);
            end
            if (rel == 4 || rel == 12) begin
                spot = {valid_n, valid_r, lines_n, lines_r};
                checks++;
                if (spot !== (rel == 4 ? {2'b10, 7'h55, 7'h00} : {2'b01, 7'h55, 7'h2A})) begin
                    errors++;
                    $display("FAIL basic_spot cyc %0d: got %h", rel, spot);
                end
            end
            if (rel == 8 || rel == 9) begin
                checks++;
                if (selector !== (rel == 9)) begin
                    errors++;
                    $display("FAIL basic_sel cyc %0d: got %b want %b", rel, selector, rel == 9);
                end
            end
        end
        park();
        fixed_data = 1'b0;
    endtask

    task automatic test_settle();
        logic esel, evn, evr;
        logic [17:0] got, want;
        garbage_mode = 1'b1;
        start_scan();
        for (int i = 0; i < 3 * DW + SC + 3; i++) begin
            step();
            model_cycle(esel, evn, evr);
            want = {esel, exp_n, exp_r, evn, evr, evr};
            got  = {selector, lines_n, lines_r, valid_n, valid_r, frame_done};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL settle_frame cyc %0d: got %h want %h", rel, got, want);
            end
            checks++;
            if (lines_n === 7'h7F || lines_r === 7'h7F) begin
                errors++;
                $display("FAIL settle_garbage cyc %0d: got n=%h r=%h want neither 7f",
                         rel, lines_n, lines_r);
            end
        end
        park();
        garbage_mode = 1'b0;
    endtask

    task automatic test_period();
        logic esel, evn, evr;
        logic last_sel;
        int   last_edge, edges, last_pulse;
        int   n_cyc;
        n_cyc      = 10 * DW + 2;
        last_sel   = selector;
        last_edge  = -1;
        edges      = 0;
        last_pulse = -1;
        start_scan();
        for (int i = 0; i < n_cyc; i++) begin
            step();
            model_cycle(esel, evn, evr);
            checks++;
            if (selector !== esel) begin
                errors++;
                $display("FAIL period_sel cyc %0d: got %b want %b", rel, selector, esel);
            end
            if (selector !== last_sel) begin
                edges++;
                if (last_edge >= 0) begin
                    checks++;
                    if (rel - last_edge !== DW) begin
                        errors++;
                        $display("FAIL period_gap cyc %0d: got %0d want %0d",
                                 rel, rel - last_edge, DW);
                    end
                end
                last_edge = rel;
                last_sel  = selector;
            end
            checks++;
            if ({valid_n, valid_r} !== {evn, evr}) begin
                errors++;
                $display("FAIL period_valid cyc %0d: got %b%b want %b%b",
                         rel, valid_n, valid_r, evn, evr);
            end
            if (valid_n || valid_r) begin
                checks++;
                if (valid_r !== (last_pulse == 0) || (valid_n & valid_r) !== 1'b0) begin
                    errors++;
                    $display("FAIL period_alternate cyc %0d: got n=%b r=%b after %0d",
                             rel, valid_n, valid_r, last_pulse);
                end
                last_pulse = valid_r ? 1 : 0;
            end
        end
        checks++;
        if (edges !== (n_cyc - 1) / DW) begin
            errors++;
            $display("FAIL period_edges: got %0d want %0d", edges, (n_cyc - 1) / DW);
        end
        park();
    endtask

    task automatic test_enable_drop();
        logic esel, evn, evr;
        logic [17:0] got, want;
        // Run into the HOLD of the r phase, then drop enable.
        start_scan();
        for (int i = 0; i < 13; i++) begin
            step();
            model_cycle(esel, evn, evr);
            want = {esel, exp_n, exp_r, evn, evr, evr};
            got  = {selector, lines_n, lines_r, valid_n, valid_r, frame_done};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL drop_run cyc %0d: got %h want %h", rel, got, want);
            end
        end
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            want = {1'b0, exp_n, exp_r, 3'b000};
            got  = {selector, lines_n, lines_r, valid_n, valid_r, frame_done};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL drop_idle %0d: got %h want %h", i, got, want);
            end
        end
        // Re-enable: full settle before the n capture; then drop on the SAMPLE edge.
        start_scan();
        for (int i = 0; i < 5; i++) begin
            if (rel == SC + 1) enable = 1'b0;
            step();
            if (rel <= SC + 2) begin
                model_cycle(esel, evn, evr);
                want = {esel, exp_n, exp_r, evn, evr, evr};
            end else begin
                want = {1'b0, exp_n, exp_r, 3'b000};
            end
            got = {selector, lines_n, lines_r, valid_n, valid_r, frame_done};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL drop_reenable cyc %0d: got %h want %h", rel, got, want);
            end
        end
        park();
    endtask

    task automatic test_reset_mid();
        logic esel, evn, evr;
        logic [17:0] got;
        int targets [2] = '{SC + 1, DW + SC + 1};
        foreach (targets[t]) begin
            start_scan();
            for (int i = 0; i < targets[t]; i++) begin
                step();
                model_cycle(esel, evn, evr);
            end
            reset = 1'b1;
            step();
            exp_n = '0;
            exp_r = '0;
            got = {selector, lines_n, lines_r, valid_n, valid_r, frame_done};
            checks++;
            if (got !== 18'h0) begin
                errors++;
                $display("FAIL reset_mid at %0d: got %h want %h", targets[t], got, 18'h0);
            end
            reset  = 1'b0;
            enable = 1'b0;
            step();
            got = {selector, lines_n, lines_r, valid_n, valid_r, frame_done};
            checks++;
            if (got !== 18'h0) begin
                errors++;
                $display("FAIL reset_mid_after at %0d: got %h want %h", targets[t], got, 18'h0);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        lines_in     = '0;
        fixed_data   = 1'b0;
        garbage_mode = 1'b0;
        prev_sel     = 1'b0;
        exp_n        = '0;
        exp_r        = '0;
        rel          = 0;
        test_reset();
        test_basic_frame();
        test_settle();
        test_period();
        test_enable_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
